// File: rtl/flgwei_tx_pkg.sv
// Shared definitions for the flag/weight load interface (transmit side and register-file receiver).
package flgwei_tx_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned ADDR_WIDTH_DEF = 5;
    localparam int unsigned WR_NUM_DEF     = 2;
    localparam int unsigned RD_NUM_DEF     = 27;

    // FSM state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CLR  = 2'd1;
    localparam logic [1:0] SEND = 2'd2;

    // Number of beats per frame: RD_NUM words plus one pad word, WR_NUM words per beat.
    function automatic int unsigned calc_num_beat(input int unsigned rd_num, input int unsigned wr_num);
        return (rd_num + 1) / wr_num;
    endfunction

    // Frame index of the first word carried by a given beat.
    function automatic int unsigned beat_base_word(input int unsigned beat, input int unsigned wr_num);
        return beat * wr_num;
    endfunction

endpackage

// File: rtl/flgwei_tx_mux.sv
// Beat selector: picks WR_NUM consecutive words of the active frame, zero beyond the last word.
module flgwei_tx_mux
    import flgwei_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned WR_NUM     = WR_NUM_DEF,
    parameter int unsigned RD_NUM     = RD_NUM_DEF
) (
    input  logic [DATA_WIDTH*RD_NUM-1:0] frame,
    input  logic [ADDR_WIDTH-1:0]        beat,
    output logic [DATA_WIDTH*WR_NUM-1:0] words_c
);

    localparam int unsigned IW = ADDR_WIDTH + 1;

    // Compare-based select; indices >= RD_NUM never match and stay zero (pad)
    always_comb begin
        words_c = '0;
        for (int k = 0; k < WR_NUM; k++) begin
            for (int j = 0; j < RD_NUM; j++) begin
                if ((IW'(beat) * IW'(WR_NUM) + IW'(k)) == IW'(j)) begin
                    words_c[k*DATA_WIDTH +: DATA_WIDTH] = frame[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/flgwei_tx.sv
// Flag/weight transmit: single-slot frame buffer, clear pulse per frame, beat serializer.
module flgwei_tx
    import flgwei_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned WR_NUM     = WR_NUM_DEF,
    parameter int unsigned RD_NUM     = RD_NUM_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         reset,
    input  logic                         load_val,
    output logic                         load_rdy,
    input  logic [DATA_WIDTH*RD_NUM-1:0] load_data,
    output logic                         dataout_clr,
    output logic                         dataout_val,
    input  logic                         dataout_rdy,
    output logic [DATA_WIDTH*WR_NUM-1:0] dataout,
    output logic                         frame_done
);

    localparam int unsigned NUM_BEAT = calc_num_beat(RD_NUM, WR_NUM);
    localparam logic [ADDR_WIDTH-1:0] LAST_BEAT = ADDR_WIDTH'(NUM_BEAT - 1);

    logic [1:0]                   state, state_d;
    logic [ADDR_WIDTH-1:0]        beat, beat_d;
    logic                         pend_full;
    logic [DATA_WIDTH*RD_NUM-1:0] pend_data;
    logic [DATA_WIDTH*RD_NUM-1:0] act_data;
    logic                         xfer;
    logic                         load_fire;
    logic [DATA_WIDTH*WR_NUM-1:0] beat_words;

    assign load_fire = load_val && !pend_full;

    // Next state, beat counter and pending->active transfer decision
    always_comb begin
        state_d = state;
        beat_d  = beat;
        xfer    = 1'b0;
        case (state)
            IDLE: begin
                if (pend_full) begin
                    xfer    = 1'b1;
                    state_d = CLR;
                end
            end
            CLR: begin
                beat_d  = '0;
                state_d = SEND;
            end
            SEND: begin
                if (dataout_rdy) begin
                    if (beat == LAST_BEAT) begin
                        beat_d = '0;
                        if (pend_full) begin
                            xfer    = 1'b1;
                            state_d = CLR;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        beat_d = beat + ADDR_WIDTH'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, beat, pending slot and active frame registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            beat      <= '0;
            pend_full <= 1'b0;
            pend_data <= '0;
            act_data  <= '0;
        end else if (reset) begin
            state     <= IDLE;
            beat      <= '0;
            pend_full <= 1'b0;
            pend_data <= '0;
            act_data  <= '0;
        end else begin
            state     <= state_d;
            beat      <= beat_d;
            pend_full <= load_fire || (pend_full && !xfer);
            if (load_fire) begin
                pend_data <= load_data;
            end
            if (xfer) begin
                act_data <= pend_data;
            end
        end
    end

    flgwei_tx_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .WR_NUM     (WR_NUM),
        .RD_NUM     (RD_NUM)
    ) u_mux (
        .frame   (act_data),
        .beat    (beat),
        .words_c (beat_words)
    );

    // Output decode from registered state; frame_done marks acceptance of the last beat
    always_comb begin
        load_rdy    = !pend_full;
        dataout_clr = (state == CLR);
        dataout_val = (state == SEND);
        dataout     = (state == SEND) ? beat_words : '0;
        frame_done  = (state == SEND) && dataout_rdy && (beat == LAST_BEAT) && !reset;
    end

endmodule

// File: tb/tb_flgwei_tx.sv
// Directed bench for flgwei_tx at default parameters.
module tb_flgwei_tx;

    localparam int unsigned DW = 32;
    localparam int unsigned WN = 2;
    localparam int unsigned RN = 27;
    localparam int unsigned NB = 14;

    logic                clk = 1'b0;
    logic                rst;
    logic                reset;
    logic                load_val;
    logic                load_rdy;
    logic [DW*RN-1:0]    load_data;
    logic                dataout_clr;
    logic                dataout_val;
    logic                dataout_rdy;
    logic [DW*WN-1:0]    dataout;
    logic                frame_done;

    int total = 0;
    int bad   = 0;

    flgwei_tx dut (
        .clk         (clk),
        .rst         (rst),
        .reset       (reset),
        .load_val    (load_val),
        .load_rdy    (load_rdy),
        .load_data   (load_data),
        .dataout_clr (dataout_clr),
        .dataout_val (dataout_val),
        .dataout_rdy (dataout_rdy),
        .dataout     (dataout),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [DW*RN-1:0] mk_frame(input logic [31:0] base);
        logic [DW*RN-1:0] f;
        f = '0;
        for (int i = 0; i < RN; i++) f[i*DW +: DW] = base + 32'(i);
        return f;
    endfunction

    function automatic logic [63:0] exp_beat(input logic [31:0] base, input int b);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < WN; k++) begin
            if (b*WN + k < RN) r[k*DW +: DW] = base + 32'(b*WN + k);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Offer a frame for one cycle, then advance to the CLR cycle and check it
    task automatic load_and_clr(input logic [31:0] base);
        load_val  = 1'b1;
        load_data = mk_frame(base);
        #1;
        chk("ld_rdy", 64'(load_rdy), 64'd1);
        cyc();
        load_val = 1'b0;
        #1;
        chk("ld_idle_val", 64'(dataout_val), 64'd0);
        chk("ld_idle_clr", 64'(dataout_clr), 64'd0);
        cyc();
        #1;
        chk("clr_pulse", 64'(dataout_clr), 64'd1);
        chk("clr_val", 64'(dataout_val), 64'd0);
        cyc();
    endtask

    int b;
    int c;

    initial begin
        rst = 1'b1; reset = 1'b0; load_val = 1'b0; load_data = '0; dataout_rdy = 1'b0;
        cyc(); cyc();
        chk("rst_load_rdy", 64'(load_rdy), 64'd1);
        chk("rst_clr", 64'(dataout_clr), 64'd0);
        chk("rst_val", 64'(dataout_val), 64'd0);
        chk("rst_data", dataout, 64'd0);
        chk("rst_done", 64'(frame_done), 64'd0);
        rst = 1'b0;
        cyc();

        // Single frame, rdy held high
        load_and_clr(32'h100);
        for (int i = 0; i < NB; i++) begin
            dataout_rdy = 1'b1;
            #1;
            chk("t1_val", 64'(dataout_val), 64'd1);
            chk("t1_beat", dataout, exp_beat(32'h100, i));
            chk("t1_done", 64'(frame_done), 64'(i == NB-1));
            if (i == 0)    chk("t1_beat0", dataout, 64'h00000101_00000100);
            if (i == NB-1) chk("t1_beat13", dataout, 64'h00000000_0000011A);
            cyc();
        end
        dataout_rdy = 1'b0;
        #1;
        chk("t1_idle_val", 64'(dataout_val), 64'd0);
        chk("t1_idle_clr", 64'(dataout_clr), 64'd0);
        chk("t1_idle_done", 64'(frame_done), 64'd0);
        cyc();

        // Backpressure: rdy pattern 1,0,0,1,0,0,...
        load_and_clr(32'h300);
        b = 0;
        c = 0;
        while (b < NB && c < 100) begin
            dataout_rdy = (c % 3 == 0);
            #1;
            chk("bp_val", 64'(dataout_val), 64'd1);
            chk("bp_beat", dataout, exp_beat(32'h300, b));
            chk("bp_done", 64'(frame_done), 64'(dataout_rdy && b == NB-1));
            if (dataout_rdy) b++;
            c++;
            cyc();
        end
        chk("bp_count", 64'(b), 64'(NB));
        dataout_rdy = 1'b0;
        #1;
        chk("bp_idle_val", 64'(dataout_val), 64'd0);
        cyc();

        // Back-to-back frames, plus an overwrite attempt while the slot is full
        load_and_clr(32'h100);
        for (int i = 0; i < NB; i++) begin
            dataout_rdy = 1'b1;
            load_val    = 1'b0;
            if (i == 3) begin
                load_val  = 1'b1;
                load_data = mk_frame(32'h200);
            end
            if (i == 5) begin
                load_val  = 1'b1;
                load_data = mk_frame(32'h400);
            end
            #1;
            if (i == 4 || i == 5) chk("b2b_load_rdy", 64'(load_rdy), 64'd0);
            chk("b2b_beat_a", dataout, exp_beat(32'h100, i));
            chk("b2b_done_a", 64'(frame_done), 64'(i == NB-1));
            cyc();
        end
        load_val = 1'b0;
        #1;
        chk("b2b_clr", 64'(dataout_clr), 64'd1);
        chk("b2b_clr_val", 64'(dataout_val), 64'd0);
        chk("b2b_clr_done", 64'(frame_done), 64'd0);
        chk("b2b_slot_free", 64'(load_rdy), 64'd1);
        cyc();
        for (int i = 0; i < NB; i++) begin
            #1;
            chk("b2b_val_b", 64'(dataout_val), 64'd1);
            chk("b2b_beat_b", dataout, exp_beat(32'h200, i));
            if (i == 0) chk("b2b_beat0_b", dataout, 64'h00000201_00000200);
            cyc();
        end
        #1;
        chk("b2b_end_val", 64'(dataout_val), 64'd0);
        chk("b2b_end_clr", 64'(dataout_clr), 64'd0);
        cyc();
        #1;
        chk("b2b_no_third", 64'(dataout_clr), 64'd0);
        dataout_rdy = 1'b0;
        cyc();

        // Synchronous reset at beat 6 with a frame pending
        load_and_clr(32'h500);
        for (int i = 0; i < 6; i++) begin
            dataout_rdy = 1'b1;
            load_val    = (i == 1);
            load_data   = mk_frame(32'h600);
            #1;
            chk("sr_beat", dataout, exp_beat(32'h500, i));
            cyc();
        end
        load_val = 1'b0;
        #1;
        chk("sr_pend_full", 64'(load_rdy), 64'd0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        chk("sr_val", 64'(dataout_val), 64'd0);
        chk("sr_done", 64'(frame_done), 64'd0);
        chk("sr_load_rdy", 64'(load_rdy), 64'd1);
        chk("sr_clr", 64'(dataout_clr), 64'd0);
        cyc();
        #1;
        chk("sr_no_restart_clr", 64'(dataout_clr), 64'd0);
        cyc();
        #1;
        chk("sr_no_restart_val", 64'(dataout_val), 64'd0);
        dataout_rdy = 1'b0;
        cyc();

        // Asynchronous reset mid-cycle during SEND, then restart
        load_and_clr(32'h700);
        dataout_rdy = 1'b1;
        cyc(); cyc();
        dataout_rdy = 1'b0;
        #1;
        chk("ar_pre_beat", dataout, exp_beat(32'h700, 2));
        #1;
        rst = 1'b1;
        #1;
        chk("ar_val", 64'(dataout_val), 64'd0);
        chk("ar_data", dataout, 64'd0);
        chk("ar_load_rdy", 64'(load_rdy), 64'd1);
        chk("ar_clr", 64'(dataout_clr), 64'd0);
        chk("ar_done", 64'(frame_done), 64'd0);
        #1;
        rst = 1'b0;
        cyc();
        load_and_clr(32'h800);
        #1;
        chk("ar_restart_val", 64'(dataout_val), 64'd1);
        chk("ar_restart_beat0", dataout, 64'h00000801_00000800);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
